// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/redirect sequencing for the 5-stage core.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; hazards resolved combinationally each cycle
// MEM_WAIT | data memory outstanding; pipeline frozen with STALL_MEM
// FLUSH    | post-redirect window; IF/ID flushed until counter reaches 0
//
// The stall code width STALL_W must match the core-wide STALL_WIDTH (2).
module hazard_ctrl #(
  parameter int                 STALL_W        = 2,
  parameter logic [STALL_W-1:0] STALL_NONE     = 2'b00,
  parameter logic [STALL_W-1:0] STALL_LOAD     = 2'b01,
  parameter logic [STALL_W-1:0] STALL_BRANCH   = 2'b10,
  parameter logic [STALL_W-1:0] STALL_MEM      = 2'b11,
  parameter int                 REDIRECT_FLUSH = 1,
  parameter int                 CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic               id_is_branch,
  input  logic [4:0]         ex_rd,
  input  logic               ex_reg_write,
  input  logic               ex_is_load,
  input  logic               ex_mispredict,
  input  logic [31:0]        ex_target,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  output logic [STALL_W-1:0] stall,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   redirect_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(REDIRECT_FLUSH);

  state_t             state, state_nxt;
  logic [2:0]         flush_cnt, flush_cnt_nxt;
  logic [STALL_W-1:0] stall_c;
  logic               flush_if_id_c, flush_id_ex_c, redirect_valid_c;

  logic src_match, load_use, br_dep, mem_busy;

  // Hazard terms; writes to x0 never create a dependency.
  always_comb begin
    src_match = (id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd));
    load_use  = ex_is_load && ex_reg_write && (ex_rd != 5'd0) && src_match;
    br_dep    = id_is_branch && ex_reg_write && !ex_is_load && (ex_rd != 5'd0) && src_match;
    mem_busy  = dmem_req && !dmem_ready;
  end

  // State and flush-window counter; reset aborts any flush in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next state and Mealy outputs. MEM_WAIT shares the RUN decision once
  // memory releases, so a mispredict held during the wait is taken then.
  always_comb begin
    state_nxt        = state;
    flush_cnt_nxt    = flush_cnt;
    stall_c          = STALL_NONE;
    flush_if_id_c    = 1'b0;
    flush_id_ex_c    = 1'b0;
    redirect_valid_c = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          stall_c   = STALL_MEM;
          state_nxt = MEM_WAIT;
        end else if (ex_mispredict) begin
          redirect_valid_c = 1'b1;
          flush_if_id_c    = 1'b1;
          flush_id_ex_c    = 1'b1;
          if (FLUSH_LOAD != 3'd0) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          state_nxt = RUN;
          if (load_use) begin
            stall_c       = STALL_LOAD;
            flush_id_ex_c = 1'b1;
          end else if (br_dep) begin
            stall_c       = STALL_BRANCH;
            flush_id_ex_c = 1'b1;
          end
        end
      end
      FLUSH: begin
        // ID holds a flushed bubble here, so load_use/br_dep are ignored.
        if (mem_busy) begin
          stall_c = STALL_MEM;
        end else if (ex_mispredict) begin
          redirect_valid_c = 1'b1;
          flush_if_id_c    = 1'b1;
          flush_id_ex_c    = 1'b1;
          if (FLUSH_LOAD != 3'd0) begin
            flush_cnt_nxt = FLUSH_LOAD;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          flush_if_id_c = 1'b1;
          flush_cnt_nxt = flush_cnt - 3'd1;
          if (flush_cnt <= 3'd1) begin
            state_nxt     = RUN;
            flush_cnt_nxt = 3'd0;
          end
        end
      end
      default: begin
        state_nxt     = RUN;
        flush_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Outputs are forced idle while reset is held, whatever the inputs do.
  always_comb begin
    stall          = rst_n ? stall_c : STALL_NONE;
    flush_if_id    = rst_n && flush_if_id_c;
    flush_id_ex    = rst_n && flush_id_ex_c;
    redirect_valid = rst_n && redirect_valid_c;
    redirect_pc    = rst_n ? ex_target : 32'd0;
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if ((stall != STALL_NONE) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect_valid && (redirect_count != '1))
        redirect_count <= redirect_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expected-result scoreboard.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, id_is_branch;
  logic        ex_reg_write, ex_is_load, ex_mispredict;
  logic [31:0] ex_target;
  logic        dmem_req, dmem_ready;
  logic [1:0]  stall;
  logic        flush_if_id, flush_id_ex, redirect_valid;
  logic [31:0] redirect_pc, stall_cycles, redirect_count;

  typedef struct {
    string       name;
    logic [1:0]  stall;
    logic        fif;
    logic        fex;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] sc;
    logic [31:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] exp_sc = 0;
  logic [31:0] exp_rc = 0;

  hazard_ctrl #(.REDIRECT_FLUSH(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_branch(id_is_branch), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_mispredict(ex_mispredict), .ex_target(ex_target),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus just after a rising edge, push the expected
  // response, then compare on the falling edge.
  task automatic step(input string name, input logic rst,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic br,
                      input logic [4:0] rd, input logic wr, input logic ld,
                      input logic mis, input logic [31:0] tgt,
                      input logic req, input logic rdy,
                      input logic [1:0] e_stall, input logic e_fif,
                      input logic e_fex, input logic e_rv);
    exp_t e, o;
    @(posedge clk);
    #1;
    rst_n = rst; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_is_branch = br; ex_rd = rd; ex_reg_write = wr; ex_is_load = ld;
    ex_mispredict = mis; ex_target = tgt; dmem_req = req; dmem_ready = rdy;
    if (!rst) begin
      exp_sc = 0;
      exp_rc = 0;
    end
    e.name = name; e.stall = e_stall; e.fif = e_fif; e.fex = e_fex; e.rv = e_rv;
    e.rpc = rst ? tgt : 32'd0; e.sc = exp_sc; e.rc = exp_rc;
    exp_q.push_back(e);
    if (rst && e_stall != 2'b00) exp_sc++;
    if (rst && e_rv) exp_rc++;
    @(negedge clk);
    o = exp_q.pop_front();
    chk({o.name, ".stall"}, 32'(stall), 32'(o.stall));
    chk({o.name, ".flush_if_id"}, 32'(flush_if_id), 32'(o.fif));
    chk({o.name, ".flush_id_ex"}, 32'(flush_id_ex), 32'(o.fex));
    chk({o.name, ".redirect_valid"}, 32'(redirect_valid), 32'(o.rv));
    chk({o.name, ".redirect_pc"}, redirect_pc, o.rpc);
    chk({o.name, ".stall_cycles"}, stall_cycles, o.sc);
    chk({o.name, ".redirect_count"}, redirect_count, o.rc);
  endtask

  task automatic idle(input string name, input logic e_fif);
    step(name, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
         32'h0000_0040, 1'b0, 1'b0, 2'b00, e_fif, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_is_branch = 0; ex_rd = 0; ex_reg_write = 0; ex_is_load = 0;
    ex_mispredict = 0; ex_target = 0; dmem_req = 0; dmem_ready = 0;

    //    name         rst  rs1 rs2 u1 u2 br  rd  wr ld mis tgt           req rdy  stall fif fex rv
    step("rst_busy",   0,   5,  0,  1, 0, 0,  5,  1, 1, 1,  32'h0000_0100, 1,  0,  2'b00, 0, 0, 0);
    idle("post_rst", 0);
    step("load_use",   1,   5,  0,  1, 0, 0,  5,  1, 1, 0,  32'h0000_0200, 0,  0,  2'b01, 0, 1, 0);
    idle("after_lu", 0);
    step("load_x0",    1,   0,  0,  1, 0, 0,  0,  1, 1, 0,  32'h0000_0200, 0,  0,  2'b00, 0, 0, 0);
    step("mispred",    1,   0,  0,  0, 0, 0,  0,  0, 0, 1,  32'h0000_0100, 0,  0,  2'b00, 1, 1, 1);
    idle("flush_win", 1);
    idle("flush_done", 0);
    step("mem_w1",     1,   0,  0,  0, 0, 0,  0,  0, 0, 1,  32'h0000_0300, 1,  0,  2'b11, 0, 0, 0);
    step("mem_w2",     1,   0,  0,  0, 0, 0,  0,  0, 0, 1,  32'h0000_0300, 1,  0,  2'b11, 0, 0, 0);
    step("mem_w3",     1,   0,  0,  0, 0, 0,  0,  0, 0, 1,  32'h0000_0300, 1,  0,  2'b11, 0, 0, 0);
    step("mem_rel",    1,   0,  0,  0, 0, 0,  0,  0, 0, 1,  32'h0000_0300, 1,  1,  2'b01 & 2'b00, 1, 1, 1);
    idle("mem_flush", 1);
    step("lu_on_br",   1,   9,  0,  1, 0, 1,  9,  1, 1, 0,  32'h0000_0400, 0,  0,  2'b01, 0, 1, 0);
    idle("gap1", 0);
    step("br_dep",     1,   0,  7,  0, 1, 1,  7,  1, 0, 0,  32'h0000_0400, 0,  0,  2'b10, 0, 1, 0);
    step("mis_lu",     1,   5,  0,  1, 0, 0,  5,  1, 1, 1,  32'h0000_0500, 0,  0,  2'b00, 1, 1, 1);
    step("flush_ignlu",1,   5,  0,  1, 0, 0,  5,  1, 1, 0,  32'h0000_0500, 0,  0,  2'b00, 1, 0, 0);
    step("mis_again",  1,   0,  0,  0, 0, 0,  0,  0, 0, 1,  32'h0000_0600, 0,  0,  2'b00, 1, 1, 1);
    step("rst_flush",  0,   0,  0,  0, 0, 0,  0,  0, 0, 0,  32'h0000_0600, 0,  0,  2'b00, 0, 0, 0);
    idle("rst_rel", 0);
    step("mis_a",      1,   0,  0,  0, 0, 0,  0,  0, 0, 1,  32'h0000_0700, 0,  0,  2'b00, 1, 1, 1);
    step("mis_reload", 1,   0,  0,  0, 0, 0,  0,  0, 0, 1,  32'h0000_0800, 0,  0,  2'b00, 1, 1, 1);
    idle("reload_win", 1);
    idle("reload_end", 0);
    idle("final", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central hazard and pipeline-sequencing controller for the 5-stage core. It generates the stall code and the flush controls consumed by the IF/ID and ID/EX pipeline registers. It also drives the PC redirect on branch mispredict and sequences multi-cycle events: data-memory wait, the post-redirect flush window, and branch-operand dependency. It sits beside the decode stage and observes the ID, EX and data-memory interfaces.

## Interface
- STALL_W, 2: stall code width; must equal `STALL_WIDTH`.
- STALL_NONE / STALL_LOAD / STALL_BRANCH / STALL_MEM, 2'b00 / 2'b01 / 2'b10 / 2'b11: stall encodings.
- REDIRECT_FLUSH, 1: extra IF/ID flush cycles after a redirect, legal range 0..7.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1 / rs2.
- id_is_branch  in  1  ID instruction is a conditional branch; compare is done in ID.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_reg_write  in  1  EX instruction writes ex_rd.
- ex_is_load  in  1  EX instruction is a load.
- ex_mispredict  in  1  branch resolved in EX disagrees with the prediction.
- ex_target  in  32  correct next PC for the mispredicted branch.
- dmem_req  in  1  MEM stage has an outstanding data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall  out  STALL_W  stall code to the pipeline registers.
- flush_if_id  out  1  zero the instruction/bp/BTB fields entering ID.
- flush_id_ex  out  1  insert a bubble into EX.
- redirect_valid  out  1  fetch must load redirect_pc next edge.
- redirect_pc  out  32  redirect target.
- stall_cycles  out  CNT_W  cycles with stall != STALL_NONE, saturating.
- redirect_count  out  CNT_W  number of redirects issued, saturating.

## Operation
- State machine has three states: RUN, MEM_WAIT, FLUSH.
- Outputs stall, flush_*, redirect_* are combinational from state and inputs (Mealy). Counters and state are registered.
- Hazard terms:
  - load_use = ex_is_load & ex_reg_write & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - br_dep = id_is_branch & ex_reg_write & !ex_is_load & ex_rd≠0 & same source match.
  - mem_busy = dmem_req & !dmem_ready.
- Priority, highest first: mem_busy > ex_mispredict > load_use > br_dep.
- RUN:
  - mem_busy: stall=STALL_MEM; no flush or redirect; go to MEM_WAIT.
  - else ex_mispredict: redirect_valid=1, redirect_pc=ex_target, flush_if_id=1, flush_id_ex=1, stall=NONE. Go to FLUSH with counter=REDIRECT_FLUSH if REDIRECT_FLUSH>0, else stay in RUN.
  - else load_use: stall=STALL_LOAD, flush_id_ex=1.
  - else br_dep: stall=STALL_BRANCH, flush_id_ex=1.
  - else all outputs idle.
- MEM_WAIT:
  - stall=STALL_MEM while mem_busy.
  - When dmem_ready=1, that cycle is evaluated exactly as RUN with mem_busy=0, and the next state is chosen as in RUN.
  - A mispredict held in EX during the wait is therefore serviced on the release cycle.
- FLUSH:
  - flush_if_id=1 and stall=NONE each cycle; counter decrements; return to RUN when it reaches 0.
  - mem_busy still takes priority: stall=STALL_MEM and the counter freezes.
  - A new ex_mispredict restarts the redirect and reloads the counter.
  - load_use and br_dep are ignored, because ID holds a flushed bubble.
- ex_rd==0 never creates a hazard.
- When idle, redirect_pc = ex_target (don't-care for the consumer).

## Timing
- While rst_n=0: state=RUN, counters=0, and all outputs are 0 / STALL_NONE regardless of inputs.
- Reset may be asserted in any state; the FSM aborts with no residual flush.
- Deassertion is synchronised externally.
- Hazard response has zero latency: stall and flush are valid in the same cycle the inputs are.
- A load-use stall lasts exactly 1 cycle; after it the load has left EX.
- A redirect is a single-cycle pulse; total IF/ID flush duration is 1+REDIRECT_FLUSH cycles.
- stall_cycles increments on each edge where stall≠NONE; redirect_count increments on each edge where redirect_valid=1. Both hold at all-ones.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → stall=2'b01 and flush_id_ex=1 for 1 cycle; stall_cycles=1.
- Load to x0: same stimulus with ex_rd=0 → stall=2'b00, no flush.
- Mispredict: ex_mispredict=1, ex_target=0x0000_0100, REDIRECT_FLUSH=1 → redirect_valid=1 and redirect_pc=0x100 for 1 cycle; flush_if_id=1 for 2 cycles; redirect_count=1.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, with ex_mispredict=1 held → stall=2'b11 for 3 cycles, no redirect; on the dmem_ready=1 cycle, redirect_valid=1.
- Simultaneous load_use and br_dep → stall=STALL_LOAD only. Mispredict plus load_use → redirect taken, stall=NONE.
- Reset asserted in FLUSH with counter=1 → outputs 0 immediately; after release, flush_if_id=0 and counters=0.
